// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter with a one-entry holding buffer, MSB first.
// A bit advances only on edges with en=1; the buffer refills the shifter with no idle bit.
module piso_serializer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] load_data,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic             en,
   output logic             serial_out,
   output logic             serial_valid,
   output logic             frame_start,
   output logic             word_done,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state;
   logic [WIDTH-1:0] shifter;
   logic [WIDTH-1:0] hold_buf;
   logic [CW-1:0]    bit_cnt;
   logic             hold_full;
   logic             last_bit;
   logic             transfer;
   logic             accept;

   // accept needs an empty buffer and transfer needs a full one, so they never coincide
   always_comb begin
      last_bit = (state == SHIFT) && en && (bit_cnt == LAST);
      transfer = hold_full && ((state == IDLE) || last_bit);
      accept   = load_valid && !hold_full;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         shifter   <= '0;
         hold_buf  <= '0;
         bit_cnt   <= '0;
         hold_full <= 1'b0;
         word_done <= 1'b0;
      end else begin
         word_done <= last_bit;

         if (accept) begin
            hold_buf  <= load_data;
            hold_full <= 1'b1;
         end else if (transfer) begin
            hold_full <= 1'b0;
         end

         if (transfer) begin
            shifter <= hold_buf;
            bit_cnt <= '0;
            state   <= SHIFT;
         end else if (last_bit) begin
            // clearing the shifter keeps serial_out low while idle
            shifter <= '0;
            bit_cnt <= '0;
            state   <= IDLE;
         end else if ((state == SHIFT) && en) begin
            shifter <= {shifter[WIDTH-2:0], 1'b0};
            bit_cnt <= bit_cnt + 1'b1;
         end
      end
   end

   assign load_ready   = !hold_full;
   assign serial_out   = shifter[WIDTH-1];
   assign serial_valid = (state == SHIFT);
   assign frame_start  = (state == SHIFT) && (bit_cnt == '0);
   assign busy         = (state == SHIFT) || hold_full;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: fixed words with hand-derived bit
// sequences, cycle positions and pulse counts.
module tb_piso_serializer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] load_data = '0;
   logic       load_valid = 1'b0;
   logic       load_ready;
   logic       en = 1'b0;
   logic       serial_out;
   logic       serial_valid;
   logic       frame_start;
   logic       word_done;
   logic       busy;

   int checks = 0;
   int failures = 0;

   logic [7:0] txq[$];
   bit         rxbits[$];
   int vcnt, fs_cnt, fs_bad, wd_cnt, first_v, last_v, last_wd, lr_low, acc_cnt;

   piso_serializer #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid),
      .load_ready(load_ready), .en(en), .serial_out(serial_out),
      .serial_valid(serial_valid), .frame_start(frame_start),
      .word_done(word_done), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic clear_stats();
      rxbits.delete();
      vcnt = 0; fs_cnt = 0; fs_bad = 0; wd_cnt = 0;
      first_v = -1; last_v = -1; last_wd = -1; lr_low = 0; acc_cnt = 0;
   endtask

   function automatic logic [7:0] rx_word(input int k);
      logic [7:0] w = '0;
      for (int i = 0; i < 8; i++) w = {w[6:0], logic'(rxbits[8*k+i])};
      return w;
   endfunction

   // mode 0: en=1; mode 1: en on odd samples; mode 2: en=0 until sample 6
   task automatic run(input int n, input int mode);
      for (int k = 0; k < n; k++) begin
         logic took;
         case (mode)
            1:       en = (k % 2) == 1;
            2:       en = (k >= 6);
            default: en = 1'b1;
         endcase
         load_valid = (txq.size() > 0);
         load_data  = (txq.size() > 0) ? txq[0] : 8'h00;
         took = load_valid && load_ready;
         if (took) acc_cnt++;
         if (!load_ready) lr_low++;
         if (frame_start) begin
            fs_cnt++;
            if ((rxbits.size() % 8) != 0) fs_bad++;
         end
         if (serial_valid) begin
            if (first_v < 0) first_v = k;
            last_v = k;
            vcnt++;
            if (en) rxbits.push_back(serial_out);
         end
         if (word_done) begin
            wd_cnt++;
            last_wd = k;
         end
         @(posedge clk); #1;
         if (took) void'(txq.pop_front());
      end
      load_valid = 1'b0;
      en = 1'b0;
   endtask

   initial begin
      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_serial_out", serial_out, 0);
      check("rst_serial_valid", serial_valid, 0);
      check("rst_frame_start", frame_start, 0);
      check("rst_word_done", word_done, 0);
      check("rst_busy", busy, 0);
      check("rst_load_ready", load_ready, 1);
      rst = 1'b0;
      @(posedge clk); #1;

      // single word A5, en=1
      clear_stats(); txq = '{8'hA5};
      run(14, 0);
      check("a5_first_valid", first_v, 2);
      check("a5_valid_cycles", vcnt, 8);
      check("a5_frame_start", fs_cnt, 1);
      check("a5_fs_position", fs_bad, 0);
      check("a5_word_done_cnt", wd_cnt, 1);
      check("a5_word_done_pos", last_wd, 10);
      check("a5_bits", rxbits.size(), 8);
      check("a5_word", rx_word(0), 8'hA5);
      check("a5_idle_out", serial_out, 0);
      check("a5_idle_busy", busy, 0);

      // back-to-back stream A5, 3C, FF
      clear_stats(); txq = '{8'hA5, 8'h3C, 8'hFF};
      run(30, 0);
      check("st_valid_cycles", vcnt, 24);
      check("st_contiguous", last_v - first_v + 1, 24);
      check("st_frame_start", fs_cnt, 3);
      check("st_fs_position", fs_bad, 0);
      check("st_word_done", wd_cnt, 3);
      check("st_ready_low", lr_low, 15);
      check("st_bits", rxbits.size(), 24);
      check("st_word0", rx_word(0), 8'hA5);
      check("st_word1", rx_word(1), 8'h3C);
      check("st_word2", rx_word(2), 8'hFF);

      // 81 with en alternating: each bit held two cycles
      clear_stats(); txq = '{8'h81};
      run(22, 1);
      check("alt_valid_cycles", vcnt, 16);
      check("alt_frame_start", fs_cnt, 2);
      check("alt_word_done", wd_cnt, 1);
      check("alt_word_done_pos", last_wd, 18);
      check("alt_bits", rxbits.size(), 8);
      check("alt_word", rx_word(0), 8'h81);

      // reset mid-word of F0 with 0F buffered
      clear_stats(); txq = '{8'hF0, 8'h0F};
      run(5, 0);
      check("mid_bits_before_rst", rxbits.size(), 3);
      check("mid_busy_before_rst", busy, 1);
      check("mid_buffer_full", load_ready, 0);
      rst = 1'b1;
      #1;
      check("mid_rst_serial_out", serial_out, 0);
      check("mid_rst_serial_valid", serial_valid, 0);
      check("mid_rst_frame_start", frame_start, 0);
      check("mid_rst_word_done", word_done, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_load_ready", load_ready, 1);
      load_valid = 1'b1; load_data = 8'h0F;
      repeat (2) @(posedge clk);
      #1;
      check("mid_rst_ignore_valid", load_ready, 1);
      load_valid = 1'b0;
      rst = 1'b0;
      clear_stats(); txq = '{8'h55};
      run(14, 0);
      check("post_rst_first_valid", first_v, 2);
      check("post_rst_valid_cycles", vcnt, 8);
      check("post_rst_frame_start", fs_cnt, 1);
      check("post_rst_bits", rxbits.size(), 8);
      check("post_rst_word", rx_word(0), 8'h55);
      check("post_rst_word_done", wd_cnt, 1);

      // C3 held valid while the buffer is full
      clear_stats(); txq = '{8'h11, 8'h22, 8'hC3};
      run(30, 0);
      check("hold_accepts", acc_cnt, 3);
      check("hold_valid_cycles", vcnt, 24);
      check("hold_word_done", wd_cnt, 3);
      check("hold_bits", rxbits.size(), 24);
      check("hold_word0", rx_word(0), 8'h11);
      check("hold_word1", rx_word(1), 8'h22);
      check("hold_word2", rx_word(2), 8'hC3);

      // 80 loaded with en=0: MSB and frame_start held until en rises
      clear_stats(); txq = '{8'h80};
      run(4, 2);
      check("en0_serial_out", serial_out, 1);
      check("en0_frame_start", frame_start, 1);
      check("en0_serial_valid", serial_valid, 1);
      clear_stats();
      en = 1'b0;
      @(posedge clk); #1;
      check("en0_still_held", frame_start, 1);
      en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (serial_valid) rxbits.push_back(serial_out);
         if (frame_start) fs_cnt++;
         @(posedge clk); #1;
      end
      en = 1'b0;
      check("en0_bits", rxbits.size(), 8);
      check("en0_word", rx_word(0), 8'h80);
      check("en0_frame_start_cnt", fs_cnt, 1);
      check("en0_word_done", word_done, 1);
      @(posedge clk); #1;
      check("en0_word_done_pulse", word_done, 0);
      check("en0_idle_valid", serial_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
